// File: rtl/dcollide_pair_feeder.sv
// dcollide_pair_feeder: walks a sphere table in synchronous RAM and hands every
// unordered pair (i<j) to the collision core as eight bit-exact fp32 operands.
// Sphere A stays cached while sphere B sweeps the inner loop.
// Optional feature macro: DCOLLIDE_RADIUS_CULL_EN skips pairs where either
// radius is +/-0.0, without presenting them or counting them.
module dcollide_pair_feeder #(
  parameter int N_MAX = 16,
  parameter int AW    = 4
) (
  input  logic          CLOCK_50,
  input  logic          KEY0,
  input  logic          start,
  input  logic [AW:0]   n_spheres,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [127:0]  mem_rdata,
  output logic [31:0]   x1,
  output logic [31:0]   y1,
  output logic [31:0]   z1,
  output logic [31:0]   r1,
  output logic [31:0]   x2,
  output logic [31:0]   y2,
  output logic [31:0]   z2,
  output logic [31:0]   r2,
  output logic [AW-1:0] id_a,
  output logic [AW-1:0] id_b,
  output logic          pair_valid,
  input  logic          pair_ready,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pair_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_WAIT_A, S_LOAD_B, S_WAIT_B, S_PRESENT, S_DONE
  } state_t;

  localparam logic [AW:0]   NMAX_W = (AW+1)'(N_MAX);
  localparam logic [AW:0]   TWO_W  = (AW+1)'(2);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW-1:0] TWO_A  = AW'(2);

  state_t        r_state;
  logic [AW:0]   r_n;
  logic [AW-1:0] r_i, r_j;
  logic [127:0]  r_a, r_b;
  logic [AW-1:0] r_ida, r_idb;
  logic          r_vld, r_rd, r_busy, r_done;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_cnt;

  logic [AW:0]   w_n_clamp;
  logic          w_more_b, w_more_a, w_cull;
  state_t        w_adv_state;
  logic [AW-1:0] w_adv_i, w_adv_j, w_adv_addr;
  logic          w_adv_rd;

  assign w_n_clamp = (n_spheres > NMAX_W) ? NMAX_W : n_spheres;
  assign w_more_b  = ({1'b0, r_j} + (AW+1)'(1)) < r_n;
  assign w_more_a  = ({1'b0, r_i} + TWO_W) < r_n;

`ifdef DCOLLIDE_RADIUS_CULL_EN
  // A zero radius (either sign) on A or on the incoming B record kills the pair
  assign w_cull = (r_a[30:0] == 31'd0) || (mem_rdata[30:0] == 31'd0);
`else
  assign w_cull = 1'b0;
`endif

  // Next (i,j) after a pair is retired: advance B, else move to a new A, else finish
  always_comb begin
    w_adv_state = S_DONE;
    w_adv_i     = r_i;
    w_adv_j     = r_j;
    w_adv_addr  = r_addr;
    if (w_more_b) begin
      w_adv_state = S_LOAD_B;
      w_adv_j     = r_j + ONE_A;
      w_adv_addr  = r_j + ONE_A;
    end else if (w_more_a) begin
      w_adv_state = S_LOAD_A;
      w_adv_i     = r_i + ONE_A;
      w_adv_j     = r_i + TWO_A;
      w_adv_addr  = r_i + ONE_A;
    end
    w_adv_rd = (w_adv_state != S_DONE);
  end

  // Sweep FSM; every output is a register so the core sees glitch-free operands
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ida   <= '0;
      r_idb   <= '0;
      r_vld   <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_n    <= w_n_clamp;
            r_i    <= '0;
            r_j    <= ONE_A;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_n_clamp < TWO_W) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_LOAD_A;
              r_rd    <= 1'b1;
              r_addr  <= '0;
            end
          end
        end
        S_LOAD_A: begin
          r_rd    <= 1'b0;
          r_state <= S_WAIT_A;
        end
        S_WAIT_A: begin
          r_a     <= mem_rdata;
          r_ida   <= r_i;
          r_rd    <= 1'b1;
          r_addr  <= r_j;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_rd    <= 1'b0;
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          r_b   <= mem_rdata;
          r_idb <= r_j;
          if (w_cull) begin
            // skipped pair retires immediately, uncounted
            r_state <= w_adv_state;
            r_i     <= w_adv_i;
            r_j     <= w_adv_j;
            r_addr  <= w_adv_addr;
            r_rd    <= w_adv_rd;
          end else begin
            r_vld   <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (pair_ready) begin
            r_vld   <= 1'b0;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            r_state <= w_adv_state;
            r_i     <= w_adv_i;
            r_j     <= w_adv_j;
            r_addr  <= w_adv_addr;
            r_rd    <= w_adv_rd;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd     = r_rd;
  assign mem_addr   = r_addr;
  assign x1         = r_a[127:96];
  assign y1         = r_a[95:64];
  assign z1         = r_a[63:32];
  assign r1         = r_a[31:0];
  assign x2         = r_b[127:96];
  assign y2         = r_b[95:64];
  assign z2         = r_b[63:32];
  assign r2         = r_b[31:0];
  assign id_a       = r_ida;
  assign id_b       = r_idb;
  assign pair_valid = r_vld;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pair_count = r_cnt;

endmodule

// File: tb/tb_dcollide_pair_feeder.sv
// Scoreboard bench for dcollide_pair_feeder: expected pairs are queued as
// stimulus is set up; a negedge monitor pops one per handshake.
module tb_dcollide_pair_feeder;

  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] ia;
    logic [AW-1:0] ib;
    logic [127:0]  a;
    logic [127:0]  b;
  } pair_t;

  logic          CLOCK_50 = 1'b0;
  logic          KEY0;
  logic          start;
  logic [AW:0]   n_spheres;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_rdata;
  logic [31:0]   x1, y1, z1, r1, x2, y2, z2, r2;
  logic [AW-1:0] id_a, id_b;
  logic          pair_valid;
  logic          pair_ready;
  logic          busy, done;
  logic [15:0]   pair_count;

  logic [127:0]  ram [16];
  pair_t         sb [$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            popped = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  dcollide_pair_feeder #(.N_MAX(16), .AW(AW)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .start(start), .n_spheres(n_spheres),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .x1(x1), .y1(y1), .z1(z1), .r1(r1), .x2(x2), .y2(y2), .z2(z2), .r2(r2),
    .id_a(id_a), .id_b(id_b), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  // synchronous table RAM, one cycle read latency
  always @(posedge CLOCK_50) if (mem_rd) mem_rdata <= ram[mem_addr];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] all_outs();
    return {mem_rd, mem_addr, x1, y1, z1, r1, x2, y2, z2, r2,
            id_a, id_b, pair_valid, busy, done, pair_count};
  endfunction

  // monitor: each accepted pair is popped and compared; no read overlaps a pair
  always @(negedge CLOCK_50) begin
    if (KEY0 && pair_valid) begin
      chk("rd_during_valid", 320'(mem_rd), 320'd0);
      if (pair_ready) begin
        popped++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pair: got (%0d,%0d) expected none", id_a, id_b);
        end else begin
          pair_t e;
          e = sb.pop_front();
          chk("pair", 320'({id_a, id_b, x1, y1, z1, r1, x2, y2, z2, r2}), 320'(e));
        end
      end
    end
  end

  task automatic push_pairs(input int n);
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        sb.push_back('{ia: AW'(i), ib: AW'(j), a: ram[i], b: ram[j]});
  endtask

  task automatic fill_ram();
    for (int k = 0; k < 16; k++)
      ram[k] = {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k),
                32'h3000_0000 + 32'(k), 32'h3F80_0000 | 32'(k)};
  endtask

  // start a sweep, watch until done (bounded), then check latency/reads/count
  task automatic run_sweep(input string nm, input logic [AW:0] nreq, input int exp_cnt,
                           input int exp_done, input int exp_first, input int exp_reads);
    int c, reads, first;
    bit got;
    c = 0; reads = 0; first = -1; got = 0;
    @(posedge CLOCK_50); #1 start = 1'b1; n_spheres = nreq;
    @(posedge CLOCK_50); #1 start = 1'b0;
    while (!got && c < 3000) begin
      @(negedge CLOCK_50);
      c++;
      if (c == 1) chk({nm, "_busy"}, 320'(busy), 320'd1);
      if (mem_rd) reads++;
      if (pair_valid && first < 0) first = c;
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, 320'(got), 320'd1);
    if (exp_done >= 0) chk({nm, "_done_lat"}, 320'(c), 320'(exp_done));
    chk({nm, "_first_valid"}, 320'(first), 320'(exp_first));
    chk({nm, "_reads"}, 320'(reads), 320'(exp_reads));
    chk({nm, "_pair_count"}, 320'(pair_count), 320'(exp_cnt));
    chk({nm, "_sb_empty"}, 320'(sb.size()), 320'd0);
    @(negedge CLOCK_50);
    chk({nm, "_done_pulse"}, 320'(done), 320'd0);
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!pair_valid && t < 200) begin @(posedge CLOCK_50); #1 t++; end
    chk({nm, "_valid_timeout"}, 320'(pair_valid), 320'd1);
  endtask

  initial begin
    pair_t e;
    logic [319:0] snap;
    int nd;
    KEY0 = 1'b0; start = 1'b0; n_spheres = '0; pair_ready = 1'b1;
    fill_ram();
    repeat (2) @(posedge CLOCK_50);
    #1 chk("reset_outputs", all_outs(), 320'd0);
    @(negedge CLOCK_50); KEY0 = 1'b1;

    // two-sphere sweep, operands hand-written
    ram[0] = 128'hbefc475e_00000000_3fc00000_3f000000;
    ram[1] = 128'h3efc475e_00000000_3fc00000_3f000000;
    e = '{ia: 4'd0, ib: 4'd1, a: 128'hbefc475e_00000000_3fc00000_3f000000,
          b: 128'h3efc475e_00000000_3fc00000_3f000000};
    sb.push_back(e);
    run_sweep("two", 5'd2, 1, 7, 5, 2);

    // n=4, ready high: lexicographic order, 4 A + 6 B... A reads are n-1=3 here
    fill_ram();
    push_pairs(4);
    run_sweep("n4", 5'd4, 6, 26, 5, 9);

    // backpressure on the first pair of an n=3 sweep
    push_pairs(3);
    fork
      run_sweep("bp", 5'd3, 3, -1, 5, 5);
      begin
        #2 pair_ready = 1'b0;
        wait_valid("bp");
        snap = all_outs();
        for (int k = 0; k < 10; k++) begin
          @(posedge CLOCK_50); #1;
          chk("bp_hold", all_outs(), snap);
        end
        pair_ready = 1'b1;
      end
    join

    // degenerate counts and clamping
    run_sweep("n0", 5'd0, 0, 2, -1, 0);
    run_sweep("n1", 5'd1, 0, 2, -1, 0);
    push_pairs(16);
    run_sweep("n31", 5'd31, 120, -1, 5, 135);

    // reset during the third PRESENT of an n=4 sweep
    push_pairs(4);
    popped = 0;
    @(posedge CLOCK_50); #1 pair_ready = 1'b0; start = 1'b1; n_spheres = 5'd4;
    @(posedge CLOCK_50); #1 start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      wait_valid("rst_pre");
      pair_ready = 1'b1;
      @(posedge CLOCK_50); #1 pair_ready = 1'b0;
    end
    wait_valid("rst_third");
    #2 KEY0 = 1'b0;
    #1 chk("rst_async_zero", all_outs(), 320'd0);
    chk("rst_popped", 320'(popped), 320'd2);
    sb.delete();
    @(negedge CLOCK_50); KEY0 = 1'b1; pair_ready = 1'b1;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      if (done || busy || pair_valid || mem_rd) nd++;
    end
    chk("rst_quiet", 320'(nd), 320'd0);

    // fresh sweep with an intruding start while busy
    push_pairs(4);
    fork
      run_sweep("fresh", 5'd4, 6, 26, 5, 9);
      begin
        repeat (4) @(posedge CLOCK_50);
        #2 start = 1'b1; n_spheres = 5'd2;
        @(posedge CLOCK_50); #2 start = 1'b0;
      end
    join

    // radius culling
    fill_ram();
    ram[1][31:0] = 32'h8000_0000;
`ifdef DCOLLIDE_RADIUS_CULL_EN
    sb.push_back('{ia: 4'd0, ib: 4'd2, a: ram[0], b: ram[2]});
    run_sweep("cull", 5'd3, 1, -1, 7, 5);
`else
    push_pairs(3);
    run_sweep("nocull", 5'd3, 3, -1, 5, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
